// File: rtl/alu_out_stage.sv
// ============================================================================
// Module   : alu_out_stage
// Summary  : Registered ALU result select stage with a 2-entry skid buffer.
//            Optional sticky compare-range check is enabled by ALU_CMP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_out_stage #(
    parameter int DATA_WIDTH = 4,
    parameter int RES_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            ALU_FUN,
    input  logic [RES_WIDTH-1:0]  ARITH_OUT,
    input  logic [DATA_WIDTH-1:0] LOGIC_OUT,
    input  logic [DATA_WIDTH-1:0] CMP_OUT,
    input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [RES_WIDTH-1:0]  ALU_OUT,
    output logic                  ARITH_FLAG,
    output logic                  LOGIC_FLAG,
    output logic                  CMP_FLAG,
    output logic                  SHIFT_FLAG,
    output logic                  ZERO_FLAG,
`ifdef ALU_CMP_CHECK_EN
    output logic                  CMP_ERR,
`endif
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q;
    logic [RES_WIDTH-1:0]   main_data_q, skid_data_q;
    logic [3:0]             main_tag_q,  skid_tag_q;
    logic                   main_zero_q, skid_zero_q;

    logic                   in_xfer, out_xfer;
    logic                   load_main, load_skid, pop_skid;
    logic [RES_WIDTH-1:0]   cap_data;
    logic [3:0]             cap_tag;
    logic                   cap_zero;
    logic                   unused_fun_bits;

    assign unused_fun_bits = ^ALU_FUN[1:0];

    assign in_xfer  = IN_VALID & in_ready_q;
    assign out_xfer = OUT_READY & (state_q != S_EMPTY);

    // Tag order is {ARITH, LOGIC, CMP, SHIFT}; narrow results zero-extend.
    always_comb begin
        cap_data = '0;
        cap_tag  = 4'b0000;
        case (ALU_FUN[3:2])
            2'b00: begin
                cap_data = ARITH_OUT;
                cap_tag  = 4'b1000;
            end
            2'b01: begin
                cap_data[DATA_WIDTH-1:0] = LOGIC_OUT;
                cap_tag                  = 4'b0100;
            end
            2'b10: begin
                cap_data[DATA_WIDTH-1:0] = CMP_OUT;
                cap_tag                  = 4'b0010;
            end
            default: begin
                cap_data[DATA_WIDTH-1:0] = SHIFT_OUT;
                cap_tag                  = 4'b0001;
            end
        endcase
        cap_zero = (cap_data == '0);
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = S_FULL;
                end else if (out_xfer) begin
                    state_d   = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_xfer) begin
                    pop_skid = 1'b1;
                    state_d  = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b0;
            main_data_q <= '0;
            main_tag_q  <= 4'b0000;
            main_zero_q <= 1'b0;
            skid_data_q <= '0;
            skid_tag_q  <= 4'b0000;
            skid_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
            if (load_main) begin
                main_data_q <= cap_data;
                main_tag_q  <= cap_tag;
                main_zero_q <= cap_zero;
            end else if (pop_skid) begin
                main_data_q <= skid_data_q;
                main_tag_q  <= skid_tag_q;
                main_zero_q <= skid_zero_q;
            end
            if (load_skid) begin
                skid_data_q <= cap_data;
                skid_tag_q  <= cap_tag;
                skid_zero_q <= cap_zero;
            end
        end
    end

`ifdef ALU_CMP_CHECK_EN
    logic cmp_err_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cmp_err_q <= 1'b0;
        end else if (in_xfer && (ALU_FUN[3:2] == 2'b10) && (CMP_OUT > 1)) begin
            cmp_err_q <= 1'b1;
        end
    end

    assign CMP_ERR = cmp_err_q;
`endif

    assign IN_READY   = in_ready_q;
    assign OUT_VALID  = (state_q != S_EMPTY);
    assign ALU_OUT    = main_data_q;
    assign ARITH_FLAG = main_tag_q[3];
    assign LOGIC_FLAG = main_tag_q[2];
    assign CMP_FLAG   = main_tag_q[1];
    assign SHIFT_FLAG = main_tag_q[0];
    assign ZERO_FLAG  = main_zero_q;

endmodule

`default_nettype wire
